brownout_monitor_mc: RTL

//  Multi-channel brownout detector for the supply-monitor ADC path; generalises single-rail Brownout_top.
//  Per-channel 3-level FSM (NORMAL/WARN/BROWN): two thresholds, exit hysteresis, sample debounce.
//  Per-sample fall-rate check forces BROWN on a fast drop. Sticky fault flags are readable/clearable by SW.

---
 rtl/brownout_pkg.sv | 18 +
 rtl/brownout_chan.sv | 135 +++++++++++++
 rtl/brownout_monitor_mc.sv | 58 +++++
 3 files changed

// File: rtl/brownout_pkg.sv
// Shared state encodings and default sizing for the multi-channel brownout monitor.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package brownout_pkg;

   // Per-channel supply level; the encoding is visible to SW-facing debug taps.
   typedef enum logic [1:0] {
      ST_NORMAL = 2'd0,
      ST_WARN   = 2'd1,
      ST_BROWN  = 2'd2
   } bod_state_t;

   localparam int unsigned BOD_W   = 20;   // ADC sample / threshold width
   localparam int unsigned BOD_NCH = 4;    // monitored channels
   localparam int unsigned BOD_RW  = 12;   // rate limit width
   localparam int unsigned BOD_DW  = 4;    // debounce counter width

endpackage

// File: rtl/brownout_chan.sv
// One supply channel: NORMAL/WARN/BROWN level FSM with debounce, fall-rate trip and sticky flag.
// Latency: outputs are registered, one cycle after the sample is taken.
// Backpressure: none; every cycle with adc_vld=1 is consumed, other cycles hold state.
//
// Ports: clk/rst_n (async active-low); adc_vld + adc sample; thresh1 (warn), thresh2 (brown),
//        hyst, rate_limit, deb_cnt configuration; clr_sticky; warn/brownout level flags,
//        rate_fault pulse, sticky latched fault.
module brownout_chan
   import brownout_pkg::*;
#(
   parameter int unsigned W  = BOD_W,
   parameter int unsigned RW = BOD_RW,
   parameter int unsigned DW = BOD_DW
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          adc_vld,
   input  logic [W-1:0]  adc,
   input  logic [W-1:0]  thresh1,
   input  logic [W-1:0]  thresh2,
   input  logic [W-1:0]  hyst,
   input  logic [RW-1:0] rate_limit,
   input  logic [DW-1:0] deb_cnt,
   input  logic          clr_sticky,
   output logic          warn,
   output logic          brownout,
   output logic          rate_fault,
   output logic          sticky
);

   bod_state_t    state, state_nxt;
   bod_state_t    pend, pend_nxt;     // last target that differed from state
   bod_state_t    target;
   logic [DW-1:0] cnt, cnt_nxt, cnt_inc, cnt_step, deb_max;
   logic [W-1:0]  prev;
   logic          prev_valid;
   logic [W-1:0]  drop;
   logic          rate_hit;
   logic          sticky_set;

   // Exit thresholds carry one extra bit: an overflowing sum simply can never be reached.
   logic [W:0]    t1_hyst, t2_hyst, adc_x;

   assign t1_hyst = {1'b0, thresh1} + {1'b0, hyst};
   assign t2_hyst = {1'b0, thresh2} + {1'b0, hyst};
   assign adc_x   = {1'b0, adc};

   // Level the current sample asks for; BROWN is tested first so it wins when T2 > T1.
   always_comb begin
      target = ST_NORMAL;
      case (state)
         ST_NORMAL: begin
            if (adc < thresh2)      target = ST_BROWN;
            else if (adc < thresh1) target = ST_WARN;
            else                    target = ST_NORMAL;
         end
         ST_WARN: begin
            if (adc < thresh2)          target = ST_BROWN;
            else if (adc_x >= t1_hyst)  target = ST_NORMAL;
            else                        target = ST_WARN;
         end
         default: begin
            if (adc_x < t2_hyst)        target = ST_BROWN;
            else if (adc_x >= t1_hyst)  target = ST_NORMAL;
            else                        target = ST_WARN;
         end
      endcase
   end

   // Fall-rate trip: only a falling sample can produce a nonzero drop.
   assign drop     = (adc < prev) ? (prev - adc) : '0;
   assign rate_hit = adc_vld & prev_valid & (drop > W'(rate_limit));

   // A programmed debounce of 0 behaves as 1 (change on the first qualifying sample).
   assign deb_max = (deb_cnt == '0) ? DW'(1) : deb_cnt;
   assign cnt_inc = (cnt == '1) ? cnt : cnt + DW'(1);

   always_comb begin
      state_nxt = state;
      pend_nxt  = pend;
      cnt_nxt   = cnt;
      cnt_step  = '0;
      if (adc_vld) begin
         if (rate_hit) begin
            state_nxt = ST_BROWN;
            cnt_nxt   = '0;
         end else if (target == state) begin
            cnt_nxt = '0;
         end else begin
            if (target == pend) begin
               cnt_step = cnt_inc;
            end else begin
               cnt_step = DW'(1);
               pend_nxt = target;
            end
            if (cnt_step >= deb_max) begin
               state_nxt = target;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt_step;
            end
         end
      end
   end

   assign sticky_set = rate_hit | ((state_nxt == ST_BROWN) && (state != ST_BROWN));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_NORMAL;
         pend       <= ST_NORMAL;
         cnt        <= '0;
         prev       <= '0;
         prev_valid <= 1'b0;
         warn       <= 1'b0;
         brownout   <= 1'b0;
         rate_fault <= 1'b0;
         sticky     <= 1'b0;
      end else begin
         state      <= state_nxt;
         pend       <= pend_nxt;
         cnt        <= cnt_nxt;
         if (adc_vld) begin
            prev       <= adc;
            prev_valid <= 1'b1;
         end
         warn       <= (state_nxt == ST_WARN);
         brownout   <= (state_nxt == ST_BROWN);
         rate_fault <= rate_hit;
         // A new fault in the same cycle as a clear keeps the flag set.
         sticky     <= sticky_set | (sticky & ~clr_sticky);
      end
   end

endmodule

// File: rtl/brownout_monitor_mc.sv
// Multi-channel brownout monitor: NCH independent channel monitors plus an any-brownout summary.
// Latency: per-channel flags one cycle after the sample; BROWNOUT_ANY follows BROWNOUT combinationally.
// Backpressure: none; a sample set is consumed on every ADC_VALID cycle.
//
// Ports: CLK, RST_N (async active-low); ADC_VALID with packed ADC_IN (channel c at [c*W +: W]);
//        shared BOD_THRESH1/BOD_THRESH2/HYST/RATE_LIMIT/DEB_CNT; per-channel CLR_STICKY;
//        per-channel WARN/BROWNOUT/RATE_FAULT/STICKY; BROWNOUT_ANY.
module brownout_monitor_mc
   import brownout_pkg::*;
#(
   parameter int unsigned W   = BOD_W,
   parameter int unsigned NCH = BOD_NCH,
   parameter int unsigned RW  = BOD_RW,
   parameter int unsigned DW  = BOD_DW
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             ADC_VALID,
   input  logic [NCH*W-1:0] ADC_IN,
   input  logic [W-1:0]     BOD_THRESH1,
   input  logic [W-1:0]     BOD_THRESH2,
   input  logic [W-1:0]     HYST,
   input  logic [RW-1:0]    RATE_LIMIT,
   input  logic [DW-1:0]    DEB_CNT,
   input  logic [NCH-1:0]   CLR_STICKY,
   output logic [NCH-1:0]   WARN,
   output logic [NCH-1:0]   BROWNOUT,
   output logic [NCH-1:0]   RATE_FAULT,
   output logic [NCH-1:0]   STICKY,
   output logic             BROWNOUT_ANY
);

   for (genvar c = 0; c < NCH; c++) begin : g_chan
      brownout_chan #(
         .W  (W),
         .RW (RW),
         .DW (DW)
      ) u_chan (
         .clk        (CLK),
         .rst_n      (RST_N),
         .adc_vld    (ADC_VALID),
         .adc        (ADC_IN[c*W +: W]),
         .thresh1    (BOD_THRESH1),
         .thresh2    (BOD_THRESH2),
         .hyst       (HYST),
         .rate_limit (RATE_LIMIT),
         .deb_cnt    (DEB_CNT),
         .clr_sticky (CLR_STICKY[c]),
         .warn       (WARN[c]),
         .brownout   (BROWNOUT[c]),
         .rate_fault (RATE_FAULT[c]),
         .sticky     (STICKY[c])
      );
   end

   assign BROWNOUT_ANY = |BROWNOUT;

endmodule
